// File: rtl/cache_meta_ctrl_if.sv
// Bundle between the cache metadata controller, its requester, the metadata
// array and the fill engine.
//
// Handshake: an access is offered by holding req high with addr stable; the
// controller accepts it only in an idle cycle (busy low) and answers with a
// single-cycle done pulse carrying hit/hit_way. A fill is requested by holding
// fill_req high with fill_addr stable until fill_done is seen for one cycle;
// fill_done is meaningful only while fill_req is high.
interface cache_meta_ctrl_if;
   logic        req;
   logic [15:0] addr;
   logic [7:0]  meta_rd0;
   logic [7:0]  meta_rd1;
   logic        fill_done;
   logic [63:0] block_enable;
   logic [7:0]  meta_wr_data;
   logic        meta_write0;
   logic        meta_write1;
   logic        fill_req;
   logic [15:0] fill_addr;
   logic        busy;
   logic        done;
   logic        hit;
   logic        hit_way;

   // Environment side: requester, metadata array and memory.
   modport master (
      output req, addr, meta_rd0, meta_rd1, fill_done,
      input  block_enable, meta_wr_data, meta_write0, meta_write1,
             fill_req, fill_addr, busy, done, hit, hit_way
   );

   // Controller side.
   modport slave (
      input  req, addr, meta_rd0, meta_rd1, fill_done,
      output block_enable, meta_wr_data, meta_write0, meta_write1,
             fill_req, fill_addr, busy, done, hit, hit_way
   );
endinterface

// File: rtl/cache_meta_ctrl.sv
// Metadata controller for a 64-set, 2-way cache with 16-bit addresses
// (tag = addr[15:10], index = addr[9:4]). Each access reads both ways'
// metadata, decides hit or victim, waits for a fill on a miss, then
// rewrites the target way as valid/most-recent and the other way as victim.
// Metadata byte: [7] valid, [6] lru (1 = victim candidate), [5:0] tag.
module cache_meta_ctrl (
   input  logic             clk,
   input  logic             rst,
   cache_meta_ctrl_if.slave bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      FILL_WAIT = 3'd2,
      WR_SELF   = 3'd3,
      WR_OTHER  = 3'd4
   } state_t;

   state_t     state;
   logic [5:0] tag_q;
   logic [5:0] index_q;
   logic [7:0] meta0_q;
   logic [7:0] meta1_q;
   logic       way_q;
   logic       hit_q;

   logic       hit0;
   logic       hit1;
   logic       lookup_hit;
   logic       lookup_way;
   logic       unused_addr_bits;

   // Block offset bits never influence metadata.
   assign unused_addr_bits = ^bus.addr[3:0];

   assign dbg_state = state;

   function automatic logic [63:0] onehot(input logic [5:0] idx);
      onehot = 64'd1 << idx;
   endfunction

   // Hit detection and victim choice from the metadata read in LOOKUP.
   always_comb begin
      hit0       = bus.meta_rd0[7] && (bus.meta_rd0[5:0] == tag_q);
      hit1       = bus.meta_rd1[7] && (bus.meta_rd1[5:0] == tag_q);
      lookup_hit = hit0 || hit1;
      if (hit0)
         lookup_way = 1'b0;
      else if (hit1)
         lookup_way = 1'b1;
      else if (!bus.meta_rd0[7])
         lookup_way = 1'b0;
      else if (!bus.meta_rd1[7])
         lookup_way = 1'b1;
      else
         // Both valid: way 1 only when it alone carries the lru mark.
         lookup_way = bus.meta_rd1[6] && !bus.meta_rd0[6];
   end

   // Access sequencer; every output is registered and set on entry to a state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         tag_q            <= '0;
         index_q          <= '0;
         meta0_q          <= '0;
         meta1_q          <= '0;
         way_q            <= 1'b0;
         hit_q            <= 1'b0;
         bus.block_enable <= '0;
         bus.meta_wr_data <= '0;
         bus.meta_write0  <= 1'b0;
         bus.meta_write1  <= 1'b0;
         bus.fill_req     <= 1'b0;
         bus.fill_addr    <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.hit          <= 1'b0;
         bus.hit_way      <= 1'b0;
      end else begin
         // Strobes and completion flags are single-cycle unless re-armed below.
         bus.meta_wr_data <= '0;
         bus.meta_write0  <= 1'b0;
         bus.meta_write1  <= 1'b0;
         bus.done         <= 1'b0;
         bus.hit          <= 1'b0;
         bus.hit_way      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  tag_q            <= bus.addr[15:10];
                  index_q          <= bus.addr[9:4];
                  bus.block_enable <= onehot(bus.addr[9:4]);
                  bus.busy         <= 1'b1;
                  state            <= LOOKUP;
               end
            end
            LOOKUP: begin
               meta0_q <= bus.meta_rd0;
               meta1_q <= bus.meta_rd1;
               way_q   <= lookup_way;
               hit_q   <= lookup_hit;
               if (lookup_hit) begin
                  bus.meta_write0  <= !lookup_way;
                  bus.meta_write1  <= lookup_way;
                  bus.meta_wr_data <= {2'b10, tag_q};
                  state            <= WR_SELF;
               end else begin
                  bus.block_enable <= '0;
                  bus.fill_req     <= 1'b1;
                  bus.fill_addr    <= {tag_q, index_q, 4'b0000};
                  state            <= FILL_WAIT;
               end
            end
            FILL_WAIT: begin
               if (bus.fill_done) begin
                  bus.fill_req     <= 1'b0;
                  bus.fill_addr    <= '0;
                  bus.block_enable <= onehot(index_q);
                  bus.meta_write0  <= !way_q;
                  bus.meta_write1  <= way_q;
                  bus.meta_wr_data <= {2'b10, tag_q};
                  state            <= WR_SELF;
               end
            end
            WR_SELF: begin
               // The other way keeps its valid bit and tag but becomes victim.
               bus.meta_write0  <= way_q;
               bus.meta_write1  <= !way_q;
               bus.meta_wr_data <= way_q ? {meta0_q[7], 1'b1, meta0_q[5:0]}
                                         : {meta1_q[7], 1'b1, meta1_q[5:0]};
               bus.done         <= 1'b1;
               bus.hit          <= hit_q;
               bus.hit_way      <= way_q;
               state            <= WR_OTHER;
            end
            WR_OTHER: begin
               bus.block_enable <= '0;
               bus.busy         <= 1'b0;
               state            <= IDLE;
            end
            default: begin
               bus.block_enable <= '0;
               bus.fill_req     <= 1'b0;
               bus.busy         <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_meta_ctrl.sv
// Bench for cache_meta_ctrl: models the metadata array, drives accesses with
// random addresses and fill delays, and predicts every output from the
// hit/victim/LRU rules of the cache.
module tb_cache_meta_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   cache_meta_ctrl_if bus ();

   cache_meta_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Metadata array owned by the environment (written by the DUT strobes).
   logic [7:0] mem0 [64] = '{default: 8'h00};
   logic [7:0] mem1 [64] = '{default: 8'h00};
   // Reference model of what the array should hold.
   logic [7:0] ref0 [64] = '{default: 8'h00};
   logic [7:0] ref1 [64] = '{default: 8'h00};
   // Expected metadata writes, in order: {index, way, data}.
   logic [14:0] exp_q [$];

   function automatic logic [5:0] idx_of(input logic [63:0] v);
      idx_of = 6'd0;
      for (int i = 63; i >= 0; i--)
         if (v[i]) idx_of = 6'(i);
   endfunction

   function automatic logic [63:0] oh(input logic [5:0] i);
      oh = 64'd1 << i;
   endfunction

   // Array read port and write port.
   always_comb begin
      bus.meta_rd0 = 8'h00;
      bus.meta_rd1 = 8'h00;
      if (bus.block_enable != 64'd0) begin
         bus.meta_rd0 = mem0[idx_of(bus.block_enable)];
         bus.meta_rd1 = mem1[idx_of(bus.block_enable)];
      end
   end

   always @(posedge clk) begin
      if (bus.meta_write0) mem0[idx_of(bus.block_enable)] <= bus.meta_wr_data;
      if (bus.meta_write1) mem1[idx_of(bus.block_enable)] <= bus.meta_wr_data;
   end

   // Output snapshot; data and fill_addr only matter while qualified.
   function automatic logic [94:0] snap();
      snap = {bus.block_enable, bus.meta_write0, bus.meta_write1,
              (bus.meta_write0 || bus.meta_write1) ? bus.meta_wr_data : 8'h00,
              bus.fill_req, bus.fill_req ? bus.fill_addr : 16'h0000,
              bus.busy, bus.done, bus.hit, bus.hit_way};
   endfunction

   function automatic logic [94:0] pack(input logic [63:0] be, input logic w0, input logic w1,
                                        input logic [7:0] d, input logic fr, input logic [15:0] fa,
                                        input logic bsy, input logic dn, input logic h, input logic hw);
      pack = {be, w0, w1, d, fr, fa, bsy, dn, h, hw};
   endfunction

   // Write scoreboard: every strobe must match the next expected write.
   always @(negedge clk) begin
      logic [14:0] e;
      logic [14:0] o;
      if (bus.meta_write0 || bus.meta_write1) begin
         tests_run++;
         o = {idx_of(bus.block_enable), bus.meta_write1, bus.meta_wr_data};
         if (bus.meta_write0 && bus.meta_write1) begin
            tests_failed++;
            $display("FAIL write_excl: both strobes high at %0t", $time);
         end else if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL write_unexp: got %h required none at %0t", o, $time);
         end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
               tests_failed++;
               $display("FAIL write_data: got %h required %h at %0t", o, e, $time);
            end
         end
      end
   end

   // One access; returns at the negedge of the done cycle.
   task automatic do_access(input logic [15:0] a, input int fdelay, input bit keep_req,
                            input int start_lat, input bit noise, input string name);
      logic [5:0]  idx;
      logic [5:0]  tg;
      logic [7:0]  m0;
      logic [7:0]  m1;
      logic [7:0]  mo;
      logic        exp_hit;
      logic        way;
      logic [94:0] e;
      int          lat;
      idx = a[9:4];
      tg  = a[15:10];
      m0  = ref0[idx];
      m1  = ref1[idx];
      if (m0[7] && m0[5:0] == tg) begin exp_hit = 1'b1; way = 1'b0; end
      else if (m1[7] && m1[5:0] == tg) begin exp_hit = 1'b1; way = 1'b1; end
      else begin
         exp_hit = 1'b0;
         if (!m0[7]) way = 1'b0;
         else if (!m1[7]) way = 1'b1;
         else if (m1[6] && !m0[6]) way = 1'b1;
         else way = 1'b0;
      end
      mo = way ? m0 : m1;
      exp_q.push_back({idx, way, 2'b10, tg});
      exp_q.push_back({idx, !way, mo[7], 1'b1, mo[5:0]});

      bus.req  = 1'b1;
      bus.addr = a;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end while (!bus.busy && lat < 4);
      tests_run++;
      if (lat != start_lat) begin
         tests_failed++;
         $display("FAIL %s start: got %0d cycles required %0d", name, lat, start_lat);
      end
      if (!keep_req) bus.req = 1'b0;

      e = pack(oh(idx), 1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (snap() !== e) begin
         tests_failed++;
         $display("FAIL %s lookup: got %h required %h", name, snap(), e);
      end

      @(negedge clk);
      if (!exp_hit) begin
         e = pack(64'd0, 1'b0, 1'b0, 8'h00, 1'b1, {tg, idx, 4'b0000}, 1'b1, 1'b0, 1'b0, 1'b0);
         tests_run++;
         if (snap() !== e) begin
            tests_failed++;
            $display("FAIL %s fill_wait: got %h required %h", name, snap(), e);
         end
         bus.fill_done = 1'b0;
         for (int i = 0; i < fdelay; i++) begin
            @(negedge clk);
            tests_run++;
            if (snap() !== e) begin
               tests_failed++;
               $display("FAIL %s fill_hold: got %h required %h", name, snap(), e);
            end
         end
         bus.fill_done = 1'b1;
         @(negedge clk);
      end
      bus.fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;

      e = pack(oh(idx), !way, way, {2'b10, tg}, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (snap() !== e) begin
         tests_failed++;
         $display("FAIL %s wr_self: got %h required %h", name, snap(), e);
      end

      @(negedge clk);
      bus.fill_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      e = pack(oh(idx), way, !way, {mo[7], 1'b1, mo[5:0]}, 1'b0, 16'h0, 1'b1, 1'b1, exp_hit, way);
      tests_run++;
      if (snap() !== e) begin
         tests_failed++;
         $display("FAIL %s wr_other: got %h required %h", name, snap(), e);
      end

      if (way) begin
         ref1[idx] = {2'b10, tg};
         ref0[idx] = {m0[7], 1'b1, m0[5:0]};
      end else begin
         ref0[idx] = {2'b10, tg};
         ref1[idx] = {m1[7], 1'b1, m1[5:0]};
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 1'b1;
      bus.addr = 16'hFFFF;
      bus.fill_done = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (snap() !== 95'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h required 0", snap());
      end
      rst = 1'b0;
      bus.req = 1'b0;
      bus.fill_done = 1'b1;
      @(negedge clk);
      bus.fill_done = 1'b0;
      tests_run++;
      if (snap() !== 95'd0) begin
         tests_failed++;
         $display("FAIL reset_idle: got %h required 0", snap());
      end
   endtask

   task automatic test_directed();
      do_access(16'h1230, 2, 1'b0, 1, 1'b0, "miss_first");
      bus.req = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({mem0[6'h23], mem1[6'h23]} !== 16'h8440) begin
         tests_failed++;
         $display("FAIL miss_first_array: got %h required 8440", {mem0[6'h23], mem1[6'h23]});
      end
      do_access(16'h1230, 0, 1'b0, 1, 1'b0, "hit_repeat");
      bus.req = 1'b0;
      @(negedge clk);
      do_access(16'h5630, 1, 1'b0, 1, 1'b0, "victim_invalid");
      bus.req = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({mem0[6'h23], mem1[6'h23]} !== 16'hC495) begin
         tests_failed++;
         $display("FAIL victim_invalid_array: got %h required c495", {mem0[6'h23], mem1[6'h23]});
      end
      do_access(16'hFE30, 3, 1'b0, 1, 1'b0, "victim_lru");
      bus.req = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({mem0[6'h23], mem1[6'h23]} !== 16'hBFD5) begin
         tests_failed++;
         $display("FAIL victim_lru_array: got %h required bfd5", {mem0[6'h23], mem1[6'h23]});
      end
   endtask

   task automatic test_reset_in_fill();
      bus.req  = 1'b1;
      bus.addr = 16'h03A0;
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.fill_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_fill_pre: got fill_req=%b required 1", bus.fill_req);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (snap() !== 95'd0) begin
         tests_failed++;
         $display("FAIL rst_fill_drop: got %h required 0", snap());
      end
      bus.fill_done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests_run++;
         if (snap() !== 95'd0) begin
            tests_failed++;
            $display("FAIL rst_fill_ignore: got %h required 0", snap());
         end
      end
      bus.fill_done = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_access(16'h0450, 1, 1'b1, 1, 1'b1, "b2b_a");
      do_access(16'h0450, 0, 1'b1, 2, 1'b1, "b2b_b");
      do_access(16'h8850, 0, 1'b1, 2, 1'b1, "b2b_c");
      bus.req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [5:0]  idx_set [4];
      logic [15:0] a;
      bit          gap;
      idx_set = '{6'h23, 6'h05, 6'h3F, 6'h10};
      gap = 1'b1;
      for (int n = 0; n < 40; n++) begin
         a = {6'($urandom_range(0, 3)), idx_set[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
         do_access(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), gap ? 1 : 2, 1'b1, "random");
         gap = 1'($urandom_range(0, 1));
         if (gap) begin
            bus.req = 1'b0;
            @(negedge clk);
         end
      end
      bus.req = 1'b0;
      bus.fill_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_array_contents();
      for (int i = 0; i < 64; i++) begin
         tests_run++;
         if ({mem0[i], mem1[i]} !== {ref0[i], ref1[i]}) begin
            tests_failed++;
            $display("FAIL array_set_%0d: got %h required %h", i, {mem0[i], mem1[i]}, {ref0[i], ref1[i]});
         end
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL writes_missing: got %0d pending required 0", exp_q.size());
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.req       = 1'b0;
      bus.addr      = 16'h0000;
      bus.fill_done = 1'b0;
      test_reset();
      test_directed();
      test_reset_in_fill();
      test_back_to_back();
      test_random();
      test_array_contents();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/cache_meta_ctrl.md
CACHE_META_CTRL -- requirements
Module: cache_meta_ctrl

Interface
REQ-001 No parameters; geometry SHALL be fixed: 64 sets, 2 ways, 16-bit address, tag=addr[15:10], index=addr[9:4], offset=addr[3:0].
REQ-002 Metadata byte format SHALL be [7]=valid, [6]=lru (1 = this way is victim candidate), [5:0]=tag.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  1  access request, sampled only in IDLE.
REQ-006 addr  in  16  access address, captured with req.
REQ-007 meta_rd0, meta_rd1  in  8 each  way-0/way-1 metadata read back from the metadata array.
REQ-008 fill_done  in  1  memory has finished writing the missed block.
REQ-009 block_enable  out  64  one-hot set select driven to the metadata array.
REQ-010 meta_wr_data  out  8  metadata byte to write.
REQ-011 meta_write0, meta_write1  out  1 each  per-way write strobes.
REQ-012 fill_req  out  1  block fill request to memory.
REQ-013 fill_addr  out  16  block-aligned fill address {tag, index, 4'b0}.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 hit  out  1  valid with done: 1 = hit, 0 = miss.
REQ-017 hit_way  out  1  valid with done: way hit or filled.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP, FILL_WAIT, WR_SELF, WR_OTHER.
REQ-019 IDLE: block_enable=0, both write strobes=0; req=1 latches addr and moves to LOOKUP; req=0 stays.
REQ-020 LOOKUP (exactly 1 cycle): block_enable=onehot(index), writes=0; meta_rd0/meta_rd1 sampled and latched at the end of this cycle.
REQ-021 Way w hits iff meta_rdw[7]=1 and meta_rdw[5:0]=tag; if both ways match, way 0 SHALL win.
REQ-022 On hit: latch target way=w, hit flag=1, go to WR_SELF.
REQ-023 On miss: victim SHALL be the first invalid way (way 0 before way 1); if both ways are valid, the way with lru=1; if both ways or neither have lru=1, way 0. Latch hit flag=0 and go to FILL_WAIT.
REQ-024 FILL_WAIT: fill_req=1, fill_addr={tag,index,4'b0}, block_enable=0; fill_done=1 moves to WR_SELF; otherwise stay.
REQ-025 WR_SELF (1 cycle): block_enable=onehot(index), meta_write of the target way=1, meta_wr_data={1,0,tag}.
REQ-026 WR_OTHER (1 cycle): block_enable=onehot(index), meta_write of the other way=1, meta_wr_data={latched valid, 1, latched tag} of that way; done=1, hit and hit_way driven from the latched values; next state IDLE.
REQ-027 At most one write strobe SHALL be high in any cycle; strobes SHALL be high only in WR_SELF and WR_OTHER.
REQ-028 Latency: hit -- done asserted 3 cycles after the req cycle; miss -- done asserted 2 cycles after the cycle in which fill_done is sampled.
REQ-029 req is ignored while busy=1; a req asserted in the WR_OTHER (done) cycle is not accepted, and a new access starts only from IDLE.
REQ-030 fill_done is ignored outside FILL_WAIT.
REQ-031 done, hit and hit_way SHALL be 0 whenever the state is not WR_OTHER.
REQ-032 Back-to-back accesses SHALL be possible: req held high SHALL start a new access on the cycle after done.

Reset
REQ-033 rst=1 SHALL force IDLE and clear all latched registers; all outputs SHALL read 0 on the next edge, including block_enable, fill_req, busy and done.
REQ-034 rst asserted mid-operation, including in FILL_WAIT, SHALL drop fill_req and abandon the access, with no metadata writes.
REQ-035 Metadata contents are owned by the array; the controller SHALL treat all-zero reads after reset as invalid ways.

Verification
REQ-036 After reset, req with addr=0x1230 (index 0x23, tag 0x04) -> miss; fill_req with fill_addr=0x1230 until fill_done; then way0 written 0x84, way1 written 0x40; done=1, hit=0, hit_way=0.
REQ-037 Repeat addr=0x1230 -> hit way0 with done 3 cycles after req; writes are way0=0x84, then way1={v1,1,tag1}.
REQ-038 With way0 valid (tag 0x04, lru=0) and way1 invalid, addr=0x5630 (tag 0x15) -> victim way1, which is written 0x95; way0 then rewritten 0xC4.
REQ-039 With both ways valid and way0 lru=1, a new tag misses -> victim way0, and fill_addr carries the new tag.
REQ-040 rst pulsed during FILL_WAIT -> fill_req=0, busy=0 on the next cycle, and no write strobe ever asserted; a later fill_done is ignored.
REQ-041 req held high continuously plus fill_done pulses outside FILL_WAIT -> no early transitions, single done pulse per access, never two write strobes in the same cycle.
